// File: rtl/mem_bus_responder_pkg.sv
// Shared constants for the CPU memory-bus responder: IO decode addresses and
// default sizing parameters.
package mem_bus_responder_pkg;

  localparam int RAM_AW_DEF      = 17;
  localparam int TX_DEPTH_DEF    = 8;
  localparam int FULL_MARGIN_DEF = 2;

  localparam logic [1:0]  IO_SEL  = 2'b11;
  localparam logic [17:0] IO_UART = 18'h30000;
  localparam logic [17:0] IO_CLK  = 18'h30004;

endpackage

// File: rtl/mem_bus_responder_byte_fifo.sv
// Byte-wide TX FIFO with extended pointers; a push into a full FIFO is accepted
// only when a pop frees the head slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok,
  output logic                     pop_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Pointer MSBs differ only after the writer has lapped the reader once.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_bus_responder.sv
// CPU memory-bus responder: byte RAM, UART RX/TX window, cycle counter with a
// coherent 4-byte snapshot, and a sticky program-stop flag.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int RAM_AW      = RAM_AW_DEF,
  parameter int TX_DEPTH    = TX_DEPTH_DEF,
  parameter int FULL_MARGIN = FULL_MARGIN_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_done
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [7:0]        ram [2**RAM_AW];
  logic [17:0]       addr;
  logic              io_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       cycle_cnt;
  logic [31:0]       snapshot;
  logic              overflow_err;
  logic              fifo_push;
  logic [7:0]        fifo_push_data;
  logic              fifo_pop;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_ok;
  logic              pop_ok;
  logic              unused_addr_bits;

  assign addr             = mem_a[17:0];
  assign io_sel           = (mem_a[17:16] == IO_SEL);
  assign ram_idx          = mem_a[RAM_AW-1:0];
  assign unused_addr_bits = ^mem_a[31:18];
  assign tx_valid         = !fifo_empty;
  assign fifo_pop         = tx_valid && tx_ready;
  assign count_next       = fifo_count + CW'(push_ok) - CW'(pop_ok);

  // A zero byte on the UART window is dropped; the stop write pushes the 0x00 marker once.
  always_comb begin
    fifo_push      = 1'b0;
    fifo_push_data = mem_dout;
    if (!rst_in && mem_wr && io_sel) begin
      if (addr == IO_UART && mem_dout != 8'h00) begin
        fifo_push = 1'b1;
      end else if (addr == IO_CLK && !program_done) begin
        fifo_push      = 1'b1;
        fifo_push_data = 8'h00;
      end
    end
  end

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (tx_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in && mem_wr && !io_sel) ram[ram_idx] <= mem_dout;
  end

  // Near-full is computed from the post-edge occupancy so the CPU sees it immediately.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din        <= 8'h00;
      rx_ready       <= 1'b0;
      cycle_cnt      <= '0;
      snapshot       <= '0;
      program_done   <= 1'b0;
      overflow_err   <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      cycle_cnt      <= cycle_cnt + 32'd1;
      rx_ready       <= 1'b0;
      io_buffer_full <= (count_next >= CW'(TX_DEPTH - FULL_MARGIN));
      if (fifo_push && !push_ok) overflow_err <= 1'b1;
      if (mem_wr && io_sel && addr == IO_CLK) program_done <= 1'b1;
      if (!mem_wr) begin
        if (io_sel) begin
          case (addr)
            IO_UART: begin
              mem_din  <= rx_valid ? rx_data : 8'h00;
              rx_ready <= rx_valid;
            end
            IO_CLK: begin
              snapshot <= cycle_cnt;
              mem_din  <= cycle_cnt[7:0];
            end
            IO_CLK + 18'd1: mem_din <= snapshot[15:8];
            IO_CLK + 18'd2: mem_din <= snapshot[23:16];
            IO_CLK + 18'd3: mem_din <= snapshot[31:24];
            default:        mem_din <= 8'h00;
          endcase
        end else begin
          mem_din <= ram[ram_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench: directed scenarios plus random bus traffic compared
// against a queue-based behavioural model of the responder.
module tb_mem_bus_responder;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_ram [int];
  logic [7:0]  m_q [$];
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  logic [7:0]  m_din;
  bit          m_din_known;
  bit          m_rxr, m_done, m_ovf, m_full;

  mem_bus_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_done   (program_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one bus transaction per rising edge, evaluated on the pre-edge state.
  task automatic model_edge();
    logic [17:0] ad;
    int          key;
    int          sz;
    bit          pop, push;
    logic [7:0]  pb;
    ad   = mem_a[17:0];
    key  = int'(mem_a[16:0]);
    push = 1'b0;
    pb   = 8'h00;
    if (rst_in) begin
      m_din = 8'h00; m_din_known = 1'b1; m_rxr = 1'b0; m_q.delete();
      m_full = 1'b0; m_done = 1'b0; m_cnt = '0; m_snap = '0; m_ovf = 1'b0;
    end else begin
      m_rxr = 1'b0;
      if (!mem_wr) begin
        if (ad[17:16] == 2'b11) begin
          m_din_known = 1'b1;
          if (ad == 18'h30000) begin
            m_din = rx_valid ? rx_data : 8'h00;
            m_rxr = rx_valid;
          end else if (ad == 18'h30004) begin
            m_snap = m_cnt;
            m_din  = m_cnt[7:0];
          end else if (ad == 18'h30005) m_din = m_snap[15:8];
          else if (ad == 18'h30006)     m_din = m_snap[23:16];
          else if (ad == 18'h30007)     m_din = m_snap[31:24];
          else                          m_din = 8'h00;
        end else if (m_ram.exists(key)) begin
          m_din = m_ram[key]; m_din_known = 1'b1;
        end else begin
          m_din_known = 1'b0;
        end
      end else begin
        if (ad[17:16] == 2'b11) begin
          if (ad == 18'h30000 && mem_dout != 8'h00) begin
            push = 1'b1; pb = mem_dout;
          end else if (ad == 18'h30004 && !m_done) begin
            m_done = 1'b1; push = 1'b1; pb = 8'h00;
          end
        end else begin
          m_ram[key] = mem_dout;
        end
      end
      sz  = m_q.size();
      pop = (sz > 0) && tx_ready;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (sz < DEPTH || pop) m_q.push_back(pb);
        else                   m_ovf = 1'b1;
      end
      m_full = (m_q.size() >= DEPTH - MARGIN);
      m_cnt  = m_cnt + 32'd1;
    end
  endtask

  task automatic compare_all();
    if (m_din_known) check_output("mem_din", {24'd0, mem_din}, {24'd0, m_din});
    check_output("rx_ready", {31'd0, rx_ready}, {31'd0, m_rxr});
    check_output("tx_valid", {31'd0, tx_valid}, {31'd0, (m_q.size() != 0)});
    if (m_q.size() != 0) check_output("tx_data", {24'd0, tx_data}, {24'd0, m_q[0]});
    check_output("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, m_full});
    check_output("program_done", {31'd0, program_done}, {31'd0, m_done});
    check_output("overflow_err", {31'd0, dut.overflow_err}, {31'd0, m_ovf});
  endtask

  task automatic apply_stimulus(input logic rst, input logic [31:0] a, input logic wr,
                                input logic [7:0] d, input logic trdy,
                                input logic rxv, input logic [7:0] rxd);
    rst_in = rst; mem_a = a; mem_wr = wr; mem_dout = d;
    tx_ready = trdy; rx_valid = rxv; rx_data = rxd;
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d, input logic trdy);
    apply_stimulus(1'b0, a, 1'b1, d, trdy, 1'b0, 8'h00);
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic trdy);
    apply_stimulus(1'b0, a, 1'b0, 8'h00, trdy, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] a;
    logic [7:0]  d;
    m_din_known = 1'b0;
    m_cnt = '0; m_snap = '0;
    apply_stimulus(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check_output("reset_mem_din", {24'd0, mem_din}, 32'h0);

    bus_wr(32'h0000_0010, 8'hA5, 1'b0);
    bus_rd(32'h0000_0010, 1'b0);
    check_output("ram_raw", {24'd0, mem_din}, 32'hA5);

    for (int i = 0; i < 4; i++) bus_rd(32'h0003_0004 + i, 1'b0);

    apply_stimulus(1'b0, 32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A);
    check_output("rx_pop", {23'd0, rx_ready, mem_din}, 32'h15A);
    apply_stimulus(1'b0, 32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h77);

    bus_wr(32'h0003_0000, 8'h48, 1'b1);
    bus_wr(32'h0003_0000, 8'h00, 1'b1);
    bus_wr(32'h0003_0000, 8'h69, 1'b1);
    for (int i = 0; i < 3; i++) bus_rd(32'h0000_0010, 1'b1);

    for (int i = 0; i < 6; i++) bus_wr(32'h0003_0000, 8'h10 + 8'(i), 1'b0);
    check_output("near_full", {31'd0, io_buffer_full}, 32'h1);
    for (int i = 6; i < 9; i++) bus_wr(32'h0003_0000, 8'h10 + 8'(i), 1'b0);
    check_output("overflow_raw", {31'd0, dut.overflow_err}, 32'h1);
    bus_wr(32'h0003_0000, 8'h33, 1'b1);
    for (int i = 0; i < 10; i++) bus_rd(32'h0000_0010, 1'b1);

    bus_wr(32'h0003_0004, 8'h01, 1'b0);
    check_output("stop_raw", {23'd0, program_done, tx_data}, 32'h100);
    bus_wr(32'h0003_0004, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) bus_rd(32'h0000_0010, 1'b1);

    bus_wr(32'h0000_0020, 8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) bus_wr(32'h0003_0000, 8'hC0 + 8'(i), 1'b0);
    apply_stimulus(1'b1, 32'h0000_0020, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
    check_output("reset_flush", {30'd0, tx_valid, io_buffer_full}, 32'h0);
    bus_rd(32'h0000_0020, 1'b0);
    check_output("ram_survives_reset", {24'd0, mem_din}, 32'h3C);

    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom;
      if ($urandom_range(0, 9) < 5)
        a = {rnd[31:18], 1'b0, rnd[16], 12'd0, rnd[3:0]};
      else
        a = {rnd[31:18], 18'h30000 + 18'($urandom_range(0, 8))};
      d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      apply_stimulus(($urandom_range(0, 63) == 0), a, 1'($urandom), d,
                     1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter RAM_AW, default 17: RAM byte-address width (128 KB).
REQ-002 Parameter TX_DEPTH, default 8: TX FIFO depth in bytes, power of two, at least 4.
REQ-003 Parameter FULL_MARGIN, default 2: free-slot margin used to assert io_buffer_full.
REQ-004 clk_in  input  1  system clock; single clock domain.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 mem_a  input  32  CPU address bus; only bits 17:0 decoded.
REQ-007 mem_dout  input  8  CPU write data.
REQ-008 mem_wr  input  1  1 = write, 0 = read, sampled every cycle.
REQ-009 mem_din  output  8  read data to the CPU, registered.
REQ-010 io_buffer_full  output  1  TX FIFO near-full indication to the CPU.
REQ-011 tx_data  output  8  head byte of the TX FIFO.
REQ-012 tx_valid  output  1  TX FIFO not empty.
REQ-013 tx_ready  input  1  UART side accepts tx_data when tx_valid and tx_ready are both high.
REQ-014 rx_data  input  8  UART received byte.
REQ-015 rx_valid  input  1  rx_data is valid.
REQ-016 rx_ready  output  1  one-cycle pop strobe for rx_data.
REQ-017 program_done  output  1  sticky; set by the program-stop write.

Function
REQ-018 Decode: mem_a[17:16]==2'b11 selects IO space; any other value selects RAM at index mem_a[RAM_AW-1:0].
REQ-019 RAM read, mem_wr=0: mem_din equals RAM[index] on the next rising edge (latency 1).
REQ-020 RAM write, mem_wr=1: RAM[index] is written with mem_dout at the current edge, and mem_din holds its previous value.
REQ-021 Read-after-write to the same address in the next cycle returns the new byte.
REQ-022 cycle_cnt: 32-bit counter, cleared by reset, increments every cycle, wraps at 2^32.
REQ-023 IO read 0x30000: if rx_valid, mem_din is set to rx_data next cycle and rx_ready pulses for that same cycle; otherwise mem_din is set to 0x00 next cycle and rx_ready stays low.
REQ-024 IO read 0x30004: snapshot is loaded with cycle_cnt, and mem_din is set to cycle_cnt[7:0] next cycle.
REQ-025 IO reads 0x30005/0x30006/0x30007 return snapshot bytes 1/2/3, so a 4-byte read is coherent.
REQ-026 Any other IO read address returns 0x00.
REQ-027 IO write 0x30000 with mem_dout != 0: the byte is pushed into the TX FIFO.
REQ-028 IO write 0x30000 with mem_dout == 0: ignored.
REQ-029 IO write 0x30004: program_done is set to 1, and a 0x00 byte is pushed into the TX FIFO as the end-of-output marker.
REQ-030 IO writes to any other address are ignored.
REQ-031 TX FIFO pops on tx_valid && tx_ready; output order is write order.
REQ-032 Push while count==TX_DEPTH with no pop in the same cycle: the byte is dropped and overflow_err is set sticky.
REQ-033 Push while count==TX_DEPTH with a pop in the same cycle: both take effect and count is unchanged.
REQ-034 Push on an empty FIFO: tx_valid rises the next cycle, with no bypass path.
REQ-035 io_buffer_full = (count >= TX_DEPTH-FULL_MARGIN), registered, so the CPU always has FULL_MARGIN writes of slack.
REQ-036 After program_done is set, further 0x30004 writes have no effect; RAM and UART traffic continue.
REQ-037 FIFO read/write pointers are log2(TX_DEPTH)+1 bits with natural wrap; full and empty are derived from pointer MSB and LSB comparison.

Reset
REQ-038 On rst_in=1 at a clock edge the following are cleared:
- mem_din=0x00, rx_ready=0, tx_valid=0, io_buffer_full=0, program_done=0;
- cycle_cnt=0, snapshot=0, FIFO pointers=0, overflow_err=0.
REQ-039 RAM contents are not reset.
REQ-040 A write presented in the same cycle as reset is discarded.
REQ-041 A read presented in the same cycle as reset returns no data; mem_din=0x00 the next cycle.
REQ-042 Reset while the FIFO holds data empties it, and tx_valid is low the next cycle.

Structure
REQ-043 The shared package holds the IO constants IO_SEL=2'b11, IO_UART=18'h30000 and IO_CLK=18'h30004, together with the default parameter values.
REQ-044 The TX FIFO is the sub-module byte_fifo (push/pop/count/full/empty).
REQ-045 RAM is an inferred synchronous byte array inside mem_bus_responder.
REQ-046 Decode, counter and snapshot logic are implemented inline in mem_bus_responder.

Verification
REQ-047 RAM write then read: write 0xA5 at 0x00010, then read 0x00010 the next cycle -> mem_din=0xA5 one cycle after the read is presented.
REQ-048 Clock snapshot: with cycle_cnt=0x12345678 at the 0x30004 read, reads of 0x30004/5/6/7 in consecutive cycles -> mem_din sequence 0x78,0x56,0x34,0x12.
REQ-049 UART output: write 0x48 then 0x00 then 0x69 to 0x30000 with tx_ready=1 -> tx emits 0x48,0x69 and the 0x00 never appears.
REQ-050 Backpressure: TX_DEPTH=8, tx_ready=0, 6 writes -> io_buffer_full=1 after the 6th; writes 7 and 8 are accepted; the 9th is dropped and overflow_err=1.
REQ-051 Program stop: write to 0x30004 -> program_done=1 the next cycle and the TX stream ends with 0x00; a second stop write adds no byte.
REQ-052 Reset mid-operation: 3 bytes queued, rst_in pulsed -> tx_valid=0, io_buffer_full=0, mem_din=0x00; RAM byte written before reset is still readable.
